esp_dma_read_arbiter: RTL

Shares the single ESP DMA read path (ctrl + 64-bit channel) between two requesters inside the X-HEEP ESP accelerator wrapper: requester 0 = boot/firmware-fetch controller, requester 1 = OBI-to-ESP-DMA bridge of the X-HEEP core. It arbitrates read-control requests, issues the winner to ESP, and locks the read channel to that owner until the burst's last beat is delivered. It replaces any combinational busy-based muxing, so neither requester can steal beats from an in-flight burst.

---
 rtl/esp_dma_arb_pkg.sv | 11 +
 rtl/dma_rr_arbiter2.sv | 14 +
 rtl/esp_dma_read_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/esp_dma_arb_pkg.sv
// esp_dma_arb_pkg: shared types and constants for the ESP DMA read arbiter
package esp_dma_arb_pkg;
    typedef enum logic [1:0] {IDLE, CTRL, DATA} arb_state_e;
    typedef struct packed {
        logic [31:0] index;
        logic [31:0] length;
        logic [2:0]  size;
    } dma_rd_req_t;
    localparam logic REQ_BOOT = 1'b0;
    localparam logic REQ_CORE = 1'b1;
endpackage

// File: rtl/dma_rr_arbiter2.sv
// dma_rr_arbiter2: combinational two-way pick with optional round-robin tie break
module dma_rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       rr_en,
    output logic [1:0] gnt,
    output logic       gnt_idx
);
    // a tie alternates away from the last owner in round-robin, else requester 0 wins
    always_comb begin
        gnt_idx = (&req) ? (rr_en & ~last_owner) : (req[1] & ~req[0]);
        gnt = (|req) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    end
endmodule

// File: rtl/esp_dma_read_arbiter.sv
// esp_dma_read_arbiter: shares the ESP DMA read path between boot fetch and core bridge
module esp_dma_read_arbiter
    import esp_dma_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][31:0]      req_index,
    input  logic [1:0][31:0]      req_length,
    input  logic [1:0][2:0]       req_size,
    output logic [1:0]            req_chnl_valid,
    input  logic [1:0]            req_chnl_ready,
    output logic [DATA_WIDTH-1:0] req_chnl_data,
    output logic                  dma_read_ctrl_valid,
    input  logic                  dma_read_ctrl_ready,
    output logic [31:0]           dma_read_ctrl_data_index,
    output logic [31:0]           dma_read_ctrl_data_length,
    output logic [2:0]            dma_read_ctrl_data_size,
    input  logic                  dma_read_chnl_valid,
    output logic                  dma_read_chnl_ready,
    input  logic [DATA_WIDTH-1:0] dma_read_chnl_data,
    output logic                  owner,
    output logic                  busy
);
    arb_state_e  state, state_nxt;
    dma_rd_req_t rd;
    logic [31:0] beat_cnt;
    logic        last_owner;
    logic [1:0]  gnt;
    logic        gnt_idx;
    logic        beat_hs;

    dma_rr_arbiter2 u_arb (
        .req        (req_valid),
        .last_owner (last_owner),
        .rr_en      (ROUND_ROBIN != 0),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    assign beat_hs = (state == DATA) && dma_read_chnl_valid && req_chnl_ready[owner];
    assign busy = state != IDLE;
    assign req_chnl_data = dma_read_chnl_data;
    assign dma_read_ctrl_data_index = rd.index;
    assign dma_read_ctrl_data_length = rd.length;
    assign dma_read_ctrl_data_size = rd.size;

    // next state and handshake outputs; the channel is steered only to the owner in DATA
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        dma_read_ctrl_valid = 1'b0;
        dma_read_chnl_ready = 1'b0;
        req_chnl_valid = 2'b00;
        case (state)
            IDLE: begin
                req_ready = rst ? gnt : 2'b00;
                state_nxt = (|req_valid) ? CTRL : IDLE;
            end
            CTRL: begin
                dma_read_ctrl_valid = 1'b1;
                state_nxt = !dma_read_ctrl_ready ? CTRL : (rd.length == 32'd0) ? IDLE : DATA;
            end
            DATA: begin
                dma_read_chnl_ready = req_chnl_ready[owner];
                req_chnl_valid[owner] = dma_read_chnl_valid;
                state_nxt = (beat_hs && beat_cnt == 32'd1) ? IDLE : DATA;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nxt;

    // capture the winner's request, count beats and remember who finished last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd <= '0;
            beat_cnt <= '0;
            owner <= REQ_BOOT;
            last_owner <= REQ_CORE;
        end else begin
            if (state == IDLE && |req_valid) begin
                rd <= '{index: req_index[gnt_idx], length: req_length[gnt_idx], size: req_size[gnt_idx]};
                owner <= gnt_idx;
            end
            if (state == CTRL && dma_read_ctrl_ready) beat_cnt <= rd.length;
            if (beat_hs && beat_cnt != 32'd0) beat_cnt <= beat_cnt - 32'd1;
            if (beat_hs && beat_cnt == 32'd1) last_owner <= owner;
        end
    end
endmodule
